axi_lite_apb_bridge_mux: RTL

Parametrised AXI-Lite slave to multi-slave APB master bridge: the next generation of the single-peripheral AXI-to-APB bridge between the RISC-V AXI-Lite master and the UART. It accepts one AXI-Lite read or write at a time and decodes the address to one of `NUM_SLAVES` APB peripherals. It runs a standard SETUP/ACCESS APB transfer and returns OKAY, SLVERR or DECERR. It adds fair read/write arbitration and an APB timeout watchdog.

---
 rtl/axi_apb_pkg.sv | 18 +
 rtl/apb_addr_decode.sv | 33 +++
 rtl/axi_lite_apb_bridge_mux.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_apb_pkg.sv
// Shared types for the AXI-Lite to APB bridge family.
// Provides the AXI response codes and the bridge FSM state encoding.
package axi_apb_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } bridge_state_t;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decoder: maps a system address onto one of
// NUM_SLAVES equally sized APB windows starting at BASE_ADDR.
// Ports:
//   addr   - full system address
//   hit    - address falls inside one of the slave windows
//   idx    - slave index of the window (valid when hit)
//   offset - address offset inside the window, upper bits zero
module apb_addr_decode #(
    parameter int unsigned        ADDR_W     = 32,
    parameter int unsigned        NUM_SLAVES = 4,
    parameter int unsigned        SLV_ADDR_W = 12,
    parameter logic [ADDR_W-1:0]  BASE_ADDR  = 32'h1000_0000,
    parameter int unsigned        IDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx,
    output logic [ADDR_W-1:0] offset
);

    logic [ADDR_W-1:0] rel;
    logic [ADDR_W-1:0] win;

    // Window number relative to the base; only meaningful when addr >= base.
    always_comb begin
        rel    = addr - BASE_ADDR;
        win    = rel >> SLV_ADDR_W;
        hit    = (addr >= BASE_ADDR) && (win < ADDR_W'(NUM_SLAVES));
        idx    = IDX_W'(win);
        offset = ADDR_W'(addr[SLV_ADDR_W-1:0]);
    end

endmodule

// File: rtl/axi_lite_apb_bridge_mux.sv
// AXI-Lite slave to multi-slave APB master bridge with read/write
// round-robin arbitration and an ACCESS-phase timeout watchdog.
// Ports:
//   aclk, areset_n            - clock, async active-low reset
//   s_aw*/s_w*/s_b*           - AXI-Lite write address/data/response
//   s_ar*/s_r*                - AXI-Lite read address/data
//   m_paddr..m_pstrb, m_psel  - APB request (psel one-hot per slave)
//   m_prdata/m_pready/m_pslverr - APB responses, one lane per slave
module axi_lite_apb_bridge_mux
    import axi_apb_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       NUM_SLAVES = 4,
    parameter int unsigned       SLV_ADDR_W = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h1000_0000,
    parameter int unsigned       TIMEOUT    = 255
) (
    input  logic                         aclk,
    input  logic                         areset_n,
    input  logic [ADDR_W-1:0]            s_awaddr,
    input  logic                         s_awvalid,
    output logic                         s_awready,
    input  logic [DATA_W-1:0]            s_wdata,
    input  logic [DATA_W/8-1:0]          s_wstrb,
    input  logic                         s_wvalid,
    output logic                         s_wready,
    output logic [1:0]                   s_bresp,
    output logic                         s_bvalid,
    input  logic                         s_bready,
    input  logic [ADDR_W-1:0]            s_araddr,
    input  logic                         s_arvalid,
    output logic                         s_arready,
    output logic [DATA_W-1:0]            s_rdata,
    output logic [1:0]                   s_rresp,
    output logic                         s_rvalid,
    input  logic                         s_rready,
    output logic [ADDR_W-1:0]            m_paddr,
    output logic [NUM_SLAVES-1:0]        m_psel,
    output logic                         m_penable,
    output logic                         m_pwrite,
    output logic [DATA_W-1:0]            m_pwdata,
    output logic [DATA_W/8-1:0]          m_pstrb,
    input  logic [NUM_SLAVES*DATA_W-1:0] m_prdata,
    input  logic [NUM_SLAVES-1:0]        m_pready,
    input  logic [NUM_SLAVES-1:0]        m_pslverr
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

    bridge_state_t         state, state_d;
    logic                  last_was_write, last_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic [ADDR_W-1:0]     paddr_d;
    logic [NUM_SLAVES-1:0] psel_d;
    logic                  penable_d, pwrite_d;
    logic [DATA_W-1:0]     pwdata_d, rdata_d;
    logic [STRB_W-1:0]     pstrb_d;
    logic                  bvalid_d, rvalid_d;
    logic [1:0]            bresp_d, rresp_d;

    logic                  grant_w, grant_r, is_write;
    logic                  done;
    resp_t                 done_resp;
    logic [DATA_W-1:0]     done_rdata;
    logic [ADDR_W-1:0]     dec_addr, dec_offset;
    logic                  dec_hit;
    logic [IDX_W-1:0]      dec_idx;
    logic [DATA_W-1:0]     prdata_sel;
    logic                  pready_sel, pslverr_sel;

    // A write needs AW and W together; on a tie the type not served last wins.
    assign grant_w   = (state == IDLE) && s_awvalid && s_wvalid && (!s_arvalid || !last_was_write);
    assign grant_r   = (state == IDLE) && s_arvalid && (!(s_awvalid && s_wvalid) || last_was_write);
    assign s_awready = grant_w;
    assign s_wready  = grant_w;
    assign s_arready = grant_r;
    assign dec_addr  = grant_w ? s_awaddr : s_araddr;
    assign is_write  = (state == IDLE) ? grant_w : m_pwrite;

    apb_addr_decode #(
        .ADDR_W     (ADDR_W),
        .NUM_SLAVES (NUM_SLAVES),
        .SLV_ADDR_W (SLV_ADDR_W),
        .BASE_ADDR  (BASE_ADDR),
        .IDX_W      (IDX_W)
    ) u_decode (
        .addr   (dec_addr),
        .hit    (dec_hit),
        .idx    (dec_idx),
        .offset (dec_offset)
    );

    // Response lane of the selected slave; other slaves are ignored.
    always_comb begin
        prdata_sel  = '0;
        pready_sel  = 1'b0;
        pslverr_sel = 1'b0;
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                prdata_sel  = m_prdata[k*DATA_W +: DATA_W];
                pready_sel  = m_pready[k];
                pslverr_sel = m_pslverr[k];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state;
        last_d     = last_was_write;
        idx_d      = idx_q;
        cnt_d      = cnt;
        paddr_d    = m_paddr;
        psel_d     = m_psel;
        penable_d  = m_penable;
        pwrite_d   = m_pwrite;
        pwdata_d   = m_pwdata;
        pstrb_d    = m_pstrb;
        bvalid_d   = s_bvalid;
        bresp_d    = s_bresp;
        rvalid_d   = s_rvalid;
        rresp_d    = s_rresp;
        rdata_d    = s_rdata;
        done       = 1'b0;
        done_resp  = RESP_OKAY;
        done_rdata = '0;

        unique case (state)
            IDLE: begin
                if (grant_w || grant_r) begin
                    last_d = grant_w;
                    if (dec_hit) begin
                        state_d  = SETUP;
                        idx_d    = dec_idx;
                        paddr_d  = dec_offset;
                        psel_d   = NUM_SLAVES'(1) << dec_idx;
                        pwrite_d = grant_w;
                        if (grant_w) begin
                            pwdata_d = s_wdata;
                            pstrb_d  = s_wstrb;
                        end else begin
                            pstrb_d  = '0;
                        end
                    end else begin
                        done      = 1'b1;
                        done_resp = RESP_DECERR;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                // PREADY takes priority over the watchdog in the last allowed cycle.
                if (pready_sel) begin
                    done       = 1'b1;
                    done_resp  = pslverr_sel ? RESP_SLVERR : RESP_OKAY;
                    done_rdata = prdata_sel;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    done      = 1'b1;
                    done_resp = RESP_SLVERR;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            RESP: begin
                if ((s_bvalid && s_bready) || (s_rvalid && s_rready)) begin
                    state_d  = IDLE;
                    bvalid_d = 1'b0;
                    rvalid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (done) begin
            state_d   = RESP;
            psel_d    = '0;
            penable_d = 1'b0;
            cnt_d     = '0;
            if (is_write) begin
                bvalid_d = 1'b1;
                bresp_d  = done_resp;
            end else begin
                rvalid_d = 1'b1;
                rresp_d  = done_resp;
                rdata_d  = done_rdata;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state          <= IDLE;
            last_was_write <= 1'b1;
            idx_q          <= '0;
            cnt            <= '0;
            m_paddr        <= '0;
            m_psel         <= '0;
            m_penable      <= 1'b0;
            m_pwrite       <= 1'b0;
            m_pwdata       <= '0;
            m_pstrb        <= '0;
            s_bvalid       <= 1'b0;
            s_bresp        <= RESP_OKAY;
            s_rvalid       <= 1'b0;
            s_rresp        <= RESP_OKAY;
            s_rdata        <= '0;
        end else begin
            state          <= state_d;
            last_was_write <= last_d;
            idx_q          <= idx_d;
            cnt            <= cnt_d;
            m_paddr        <= paddr_d;
            m_psel         <= psel_d;
            m_penable      <= penable_d;
            m_pwrite       <= pwrite_d;
            m_pwdata       <= pwdata_d;
            m_pstrb        <= pstrb_d;
            s_bvalid       <= bvalid_d;
            s_bresp        <= bresp_d;
            s_rvalid       <= rvalid_d;
            s_rresp        <= rresp_d;
            s_rdata        <= rdata_d;
        end
    end

endmodule
